idex_pipe_reg: RTL and testbench

- Parametrised ID/EX pipeline register for the RISC-V pipeline, the successor of the fixed 32-bit ID/EX phase register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so stalls propagate without combinational ready paths.
- Adds a synchronous flush for branch/jump squash, x0 write suppression, and a saturating stall-cycle counter.
- Sits between decode/register-file read and the ALU stage.

---
 rtl/idex_pipe_reg.sv | 102 ++++++++++
 tb/tb_idex_pipe_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with a valid/ready handshake, 2-entry skid buffer,
// synchronous squash, x0 write suppression and a saturating stall counter.
module idex_pipe_reg #(
  parameter int N   = 32,
  parameter int OPW = 4,
  parameter int AW  = 5,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_imm,
  input  logic [N-1:0]   in_rd1,
  input  logic [N-1:0]   in_rd2,
  input  logic [OPW-1:0] in_alu_op,
  input  logic           in_reg_write,
  input  logic [AW-1:0]  in_rd_addr,
  input  logic [AW-1:0]  in_rs1_addr,
  input  logic [AW-1:0]  in_rs2_addr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_imm,
  output logic [N-1:0]   out_rd1,
  output logic [N-1:0]   out_rd2,
  output logic [OPW-1:0] out_alu_op,
  output logic           out_reg_write,
  output logic [AW-1:0]  out_rd_addr,
  output logic [AW-1:0]  out_rs1_addr,
  output logic [AW-1:0]  out_rs2_addr,
  output logic [CW-1:0]  stall_count
);

  localparam int PW = 3*N + OPW + 1 + 3*AW;
  localparam logic [CW-1:0] STALL_MAX = '1;
  localparam logic [CW-1:0] STALL_ONE = CW'(1);

  logic [PW-1:0] in_pay;
  logic [PW-1:0] out_pay;
  logic [PW-1:0] skid_pay;
  logic          skid_full;
  logic          accept;
  logic          drain;
  logic          write_en;

  // Writes to x0 are dropped at capture so EX and forwarding never see them.
  assign write_en = in_reg_write & (in_rd_addr != '0);
  assign in_pay   = {in_imm, in_rd1, in_rd2, in_alu_op, write_en,
                     in_rd_addr, in_rs1_addr, in_rs2_addr};

  assign {out_imm, out_rd1, out_rd2, out_alu_op, out_reg_write,
          out_rd_addr, out_rs1_addr, out_rs2_addr} = out_pay;

  // in_ready comes straight from a flop, so out_ready never reaches it
  // combinationally; the skid entry absorbs the one in-flight transfer.
  assign in_ready = ~skid_full;
  assign accept   = in_valid & in_ready;
  assign drain    = ~out_valid | out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pay   <= '0;
      skid_full <= 1'b0;
      // NOTE: the skid payload is reset too; it is a single register, not a
      // RAM, so the cost is trivial and X never escapes into the datapath.
      skid_pay  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_pay   <= '0;
      skid_full <= 1'b0;
    end else if (drain) begin
      if (skid_full) begin
        out_valid <= 1'b1;
        out_pay   <= skid_pay;
        skid_full <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_pay   <= in_pay;
      end else begin
        out_valid <= 1'b0;
        out_pay   <= '0;
      end
    end else if (accept) begin
      skid_pay  <= in_pay;
      skid_full <= 1'b1;
    end
  end

  // Stall statistics survive a squash; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && stall_count != STALL_MAX) begin
      stall_count <= stall_count + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed bench for idex_pipe_reg: accepted inputs are pushed to a scoreboard
// queue and popped/compared at the negedge before each output handshake.
module tb_idex_pipe_reg;

  localparam int N   = 32;
  localparam int OPW = 4;
  localparam int AW  = 5;
  localparam int CW  = 4;

  typedef struct packed {
    logic [N-1:0]   imm;
    logic [N-1:0]   rd1;
    logic [N-1:0]   rd2;
    logic [OPW-1:0] op;
    logic           rw;
    logic [AW-1:0]  rd;
    logic [AW-1:0]  rs1;
    logic [AW-1:0]  rs2;
  } pay_t;

  logic clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  pay_t din, dout;
  logic [N-1:0]   in_imm, in_rd1, in_rd2, out_imm, out_rd1, out_rd2;
  logic [OPW-1:0] in_alu_op, out_alu_op;
  logic           in_reg_write, out_reg_write;
  logic [AW-1:0]  in_rd_addr, in_rs1_addr, in_rs2_addr;
  logic [AW-1:0]  out_rd_addr, out_rs1_addr, out_rs2_addr;
  logic [CW-1:0]  stall_count;

  assign {in_imm, in_rd1, in_rd2, in_alu_op, in_reg_write,
          in_rd_addr, in_rs1_addr, in_rs2_addr} = din;
  assign dout = {out_imm, out_rd1, out_rd2, out_alu_op, out_reg_write,
                 out_rd_addr, out_rs1_addr, out_rs2_addr};

  idex_pipe_reg #(.N(N), .OPW(OPW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_rd1(in_rd1), .in_rd2(in_rd2),
    .in_alu_op(in_alu_op), .in_reg_write(in_reg_write),
    .in_rd_addr(in_rd_addr), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_rd1(out_rd1), .out_rd2(out_rd2),
    .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
    .out_rd_addr(out_rd_addr), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_pops  = 0;
  pay_t sb_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pay_t mk(input int k);
    pay_t p;
    p.imm = 32'h1000 + k;
    p.rd1 = k * 3;
    p.rd2 = ~k;
    p.op  = OPW'(k);
    p.rw  = 1'b1;
    p.rd  = AW'(k % 31 + 1);
    p.rs1 = AW'(k);
    p.rs2 = AW'(~k);
    return p;
  endfunction

  function automatic pay_t exp_of(input pay_t p);
    pay_t e;
    e    = p;
    e.rw = p.rw && (p.rd != '0);
    return e;
  endfunction

  // Advance one cycle, recording what the upcoming edge accepts or squashes.
  task automatic tick();
    if (flush) sb_q.delete();
    else if (in_valid && in_ready) sb_q.push_back(exp_of(din));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!out_valid) check("bubble_payload_zero", 128'(dout), 128'(0));
    if (reset && !flush && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 128'(dout), 128'(0));
        check("unexpected_output_valid", 128'(out_valid), 128'(0));
      end else begin
        check("scoreboard_payload", 128'(dout), 128'(sb_q.pop_front()));
        n_pops++;
      end
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    #1;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_stall", 128'(stall_count), 128'(0));
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single transfer, 1-cycle latency.
    din = '0; din.imm = 32'h10; din.rd = 5'd3; din.rw = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", 128'(out_valid), 128'(1));
    check("t1_out_imm", 128'(out_imm), 128'(32'h10));
    check("t1_out_rd_addr", 128'(out_rd_addr), 128'(3));
    check("t1_out_reg_write", 128'(out_reg_write), 128'(1));
    tick();
    check("t1_drained", 128'(out_valid), 128'(0));

    // Back-to-back stream of 8.
    for (int i = 0; i < 8; i++) begin
      din = mk(i); in_valid = 1'b1;
      tick();
      check("t2_in_ready", 128'(in_ready), 128'(1));
      check("t2_out_valid", 128'(out_valid), 128'(1));
    end
    in_valid = 1'b0;
    tick();
    check("t2_end_idle", 128'(out_valid), 128'(0));
    check("t2_pops", 128'(n_pops), 128'(9));
    check("t2_stall", 128'(stall_count), 128'(0));

    // Backpressure: output, skid, then a waiting third input.
    out_ready = 1'b0; din = mk(20); in_valid = 1'b1;
    tick();
    check("t3_first_held", 128'(dout), 128'(exp_of(mk(20))));
    check("t3_ready_after_first", 128'(in_ready), 128'(1));
    din = mk(21);
    tick();
    check("t3_skid_full_ready", 128'(in_ready), 128'(0));
    check("t3_stall_1", 128'(stall_count), 128'(1));
    din = mk(22);
    tick();
    check("t3_still_holding", 128'(dout), 128'(exp_of(mk(20))));
    check("t3_ready_low", 128'(in_ready), 128'(0));
    tick();
    out_ready = 1'b1;
    tick();
    check("t3_skid_drained", 128'(dout), 128'(exp_of(mk(21))));
    check("t3_ready_back", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("t3_third_out", 128'(dout), 128'(exp_of(mk(22))));
    tick();
    check("t3_idle", 128'(out_valid), 128'(0));
    check("t3_pops", 128'(n_pops), 128'(12));
    check("t3_stall", 128'(stall_count), 128'(3));

    // Flush with output and skid full, input offered.
    out_ready = 1'b0; din = mk(30); in_valid = 1'b1;
    tick();
    din = mk(31);
    tick();
    check("t4_skid_full", 128'(in_ready), 128'(0));
    din = mk(32); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_flush_valid", 128'(out_valid), 128'(0));
    check("t4_flush_payload", 128'(dout), 128'(0));
    check("t4_flush_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    tick(); tick();
    check("t4_no_stale", 128'(out_valid), 128'(0));

    // Flush drops an input accepted in the same cycle.
    out_ready = 1'b0; din = mk(33); in_valid = 1'b1;
    tick();
    din = mk(34); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("t4b_flush_valid", 128'(out_valid), 128'(0));
    tick(); tick();
    check("t4b_no_stale", 128'(out_valid), 128'(0));
    check("t4b_stall_kept", 128'(stall_count), 128'(6));
    check("t4b_pops", 128'(n_pops), 128'(12));

    // x0 destination suppresses writeback, rest of payload unchanged.
    din = mk(40); din.rd = '0; din.rw = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t5_x0_reg_write", 128'(out_reg_write), 128'(0));
    check("t5_x0_imm", 128'(out_imm), 128'(32'h1000 + 40));
    check("t5_x0_rd1", 128'(out_rd1), 128'(120));
    tick();

    // Stall counter saturation (CW=4), then async reset mid-stall.
    out_ready = 1'b0; din = mk(50); in_valid = 1'b1;
    tick();
    din = mk(51);
    tick();
    in_valid = 1'b0;
    check("t6_stall_7", 128'(stall_count), 128'(7));
    for (int i = 0; i < 7; i++) tick();
    check("t6_stall_14", 128'(stall_count), 128'(14));
    tick();
    check("t6_stall_15", 128'(stall_count), 128'(15));
    for (int i = 0; i < 11; i++) tick();
    check("t6_stall_sat", 128'(stall_count), 128'(15));
    #2;
    reset = 1'b0;
    sb_q.delete();
    #1;
    check("t6_async_valid", 128'(out_valid), 128'(0));
    check("t6_async_payload", 128'(dout), 128'(0));
    check("t6_async_stall", 128'(stall_count), 128'(0));
    check("t6_async_ready", 128'(in_ready), 128'(1));
    tick();
    reset = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    check("t6_nothing_after_reset", 128'(out_valid), 128'(0));

    din = mk(60); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t7_fresh_out", 128'(dout), 128'(exp_of(mk(60))));
    tick();
    check("t7_pops", 128'(n_pops), 128'(14));
    check("t7_queue_empty", 128'(sb_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
